// File: rtl/note_tone_gen.sv
// note_tone_gen: debounced eight-note square-wave tone generator
module note_tone_gen #(
  parameter int SETTLE_CYC = 16,
  parameter int DIV_SHIFT = 0
) (
  input  logic       clk,
  input  logic       reset,
  input  logic       en_c,
  input  logic       en_d,
  input  logic       en_e,
  input  logic       en_f,
  input  logic       en_g,
  input  logic       en_a,
  input  logic       en_b,
  input  logic       en_c2,
  output logic       audio,
  output logic       playing,
  output logic [2:0] note_idx,
  output logic       note_start
);
  localparam logic [0:0] IDLE = 1'b0;
  localparam logic [0:0] PLAY = 1'b1;
  localparam logic [7:0] SC = 8'(SETTLE_CYC);
  localparam logic [16:0] BASE [8] = '{17'd95556, 17'd85131, 17'd75843, 17'd71587,
                                       17'd63776, 17'd56818, 17'd50619, 17'd47778};
  logic [7:0] en, en_q, settle;
  logic [2:0] sel;
  logic [16:0] half, cnt;
  logic [0:0] state;
  logic stable, accept, sel_v, load;
  assign en = {en_c2, en_b, en_a, en_g, en_f, en_e, en_d, en_c};
  assign stable = en == en_q;
  assign accept = stable && settle == SC - 8'd1;
  assign sel_v = |en_q;
  assign half = BASE[note_idx] >> DIV_SHIFT;
  assign load = accept && sel_v && (state == IDLE || sel != note_idx);
  // lowest set enable wins
  always_comb begin
    sel = 3'd0;
    for (int i = 7; i >= 0; i--) if (en_q[i]) sel = 3'(i);
  end
  // register enables and count how long the pattern has been unchanged
  always_ff @(posedge clk) begin
    if (reset) begin
      en_q <= '0;
      settle <= '0;
    end else begin
      en_q <= en;
      settle <= !stable ? 8'd0 : settle == SC ? settle : settle + 8'd1;
    end
  end
  // note selection and half-period tone counter
  always_ff @(posedge clk) begin
    if (reset) begin
      state <= IDLE;
      audio <= 1'b0;
      playing <= 1'b0;
      note_idx <= '0;
      note_start <= 1'b0;
      cnt <= '0;
    end else if (load) begin
      state <= PLAY;
      note_idx <= sel;
      cnt <= '0;
      audio <= 1'b1;
      playing <= 1'b1;
      note_start <= 1'b1;
    end else if (accept && !sel_v) begin
      state <= IDLE;
      audio <= 1'b0;
      playing <= 1'b0;
      note_idx <= '0;
      cnt <= '0;
      note_start <= 1'b0;
    end else begin
      note_start <= 1'b0;
      if (state == PLAY) begin
        cnt <= cnt == half - 17'd1 ? 17'd0 : cnt + 17'd1;
        audio <= cnt == half - 17'd1 ? ~audio : audio;
      end else begin
        cnt <= '0;
        audio <= 1'b0;
      end
    end
  end
endmodule

// File: tb/tb_note_tone_gen.sv
// tb_note_tone_gen: scoreboard bench for note_tone_gen with SETTLE_CYC=4, DIV_SHIFT=8
module tb_note_tone_gen;
  localparam int S = 4;
  localparam int HT [8] = '{373, 332, 296, 279, 249, 221, 197, 186};
  localparam int K_START = 0;
  localparam int K_TOG = 1;
  localparam int K_STOP = 2;
  typedef struct {int k; int idx; int at;} ev_t;
  logic clk = 1'b0;
  logic reset = 1'b1;
  logic en_c = 0, en_d = 0, en_e = 0, en_f = 0, en_g = 0, en_a = 0, en_b = 0, en_c2 = 0;
  logic audio, playing, note_start;
  logic [2:0] note_idx;
  int cyc = 0;
  int tests = 0;
  int fails = 0;
  ev_t q[$];
  logic pa = 1'b0, pp = 1'b0;
  bit idle_bad = 1'b0;
  bit cur_play = 1'b0;
  int cur_idx = 0, cur_h = 0, next_tog = 0;
  logic [7:0] en_v = '0;

  note_tone_gen #(.SETTLE_CYC(S), .DIV_SHIFT(8)) dut (
    .clk(clk), .reset(reset),
    .en_c(en_c), .en_d(en_d), .en_e(en_e), .en_f(en_f),
    .en_g(en_g), .en_a(en_a), .en_b(en_b), .en_c2(en_c2),
    .audio(audio), .playing(playing), .note_idx(note_idx), .note_start(note_start)
  );

  always #5 clk = ~clk;
  always @(posedge clk) cyc <= cyc + 1;

  function automatic int lowest(input logic [7:0] e);
    for (int i = 0; i < 8; i++) if (e[i]) return i;
    return 0;
  endfunction

  function automatic void push(input int k, input int idx, input int at);
    q.push_back('{k, idx, at});
  endfunction

  function automatic void push_until(input int limit);
    while (cur_play && next_tog <= limit) begin
      push(K_TOG, cur_idx, next_tog);
      next_tog += cur_h;
    end
  endfunction

  function automatic void begin_note(input int idx, input int t);
    push(K_START, idx, t);
    cur_play = 1'b1;
    cur_idx = idx;
    cur_h = HT[idx];
    next_tog = t + cur_h;
  endfunction

  task automatic apply(input logic [7:0] e, input int hold);
    int n, t, s;
    n = cyc;
    en_v = e;
    {en_c2, en_b, en_a, en_g, en_f, en_e, en_d, en_c} = e;
    t = n + S + 1;
    s = lowest(e);
    if (hold >= S + 1) begin
      if (e != 0 && (!cur_play || s != cur_idx)) begin
        push_until(t - 1);
        begin_note(s, t);
      end else if (e == 0 && cur_play) begin
        push_until(t - 1);
        push(K_STOP, 0, t);
        cur_play = 1'b0;
      end
    end
    push_until(n + hold);
    repeat (hold) @(negedge clk);
  endtask

  task automatic chk(input string name, input int act, input int req);
    tests++;
    if (act != req) begin
      fails++;
      $display("FAIL %s: got %0d, expected %0d (cycle %0d)", name, act, req, cyc);
    end
  endtask

  task automatic pulse_reset(input int r, input int hold);
    int n, m;
    n = cyc;
    reset = 1'b1;
    push_until(n);
    if (cur_play) push(K_STOP, 0, n + 1);
    cur_play = 1'b0;
    repeat (r) @(negedge clk);
    chk("reset_audio", int'(audio), 0);
    chk("reset_playing", int'(playing), 0);
    chk("reset_note_idx", int'(note_idx), 0);
    chk("reset_note_start", int'(note_start), 0);
    m = cyc;
    reset = 1'b0;
    if (en_v != 0) begin_note(lowest(en_v), m + S + 1);
    push_until(m + hold);
    repeat (hold) @(negedge clk);
  endtask

  task automatic got(input int k);
    ev_t x;
    tests++;
    if (q.size() == 0) begin
      fails++;
      $display("FAIL unexpected_event: got kind=%0d idx=%0d at cycle %0d, expected no event", k, note_idx, cyc);
    end else begin
      x = q.pop_front();
      if (x.k != k || x.at != cyc || x.idx != int'(note_idx) ||
          (k == K_START && !(audio && playing)) || (k == K_STOP && audio)) begin
        fails++;
        $display("FAIL event: got kind=%0d idx=%0d cycle=%0d audio=%0b playing=%0b, expected kind=%0d idx=%0d cycle=%0d",
                 k, note_idx, cyc, audio, playing, x.k, x.idx, x.at);
      end
    end
  endtask

  // monitor: classify each observed output change and score it
  always @(negedge clk) begin
    if (note_start) got(K_START);
    else if (playing && audio != pa) got(K_TOG);
    else if (!playing && pp) got(K_STOP);
    if (!playing && (audio || note_idx != 0)) idle_bad = 1'b1;
    pa = audio;
    pp = playing;
  end

  initial begin
    @(negedge clk);
    pulse_reset(3, 10);
    apply(8'h01, 1200);
    apply(8'h02, 2);
    apply(8'h01, 800);
    apply(8'h80, 600);
    apply(8'h14, 700);
    apply(8'h10, 600);
    apply(8'h00, 300);
    apply(8'h40, 500);
    pulse_reset(3, 500);
    apply(8'hC0, 400);
    apply(8'h00, 50);
    chk("queue_drained", q.size(), 0);
    chk("idle_outputs_quiet", int'(idle_bad), 0);
    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end
endmodule

// File: doc/note_tone_gen.md
NOTE_TONE_GEN -- requirements
Module: note_tone_gen

Interface
REQ-001 Parameter SETTLE_CYC, default 16: cycles an enable pattern must stay unchanged before it is accepted; legal range 1..255.
REQ-002 Parameter DIV_SHIFT, default 0: right-shift applied to every half-period constant (simulation speed-up); legal range 0..8.
REQ-003 Port clk, input, 1 bit: single clock, 50 MHz; all logic on rising edge.
REQ-004 Port reset, input, 1 bit: synchronous, active-high reset.
REQ-005 Ports en_c, en_d, en_e, en_f, en_g, en_a, en_b, en_c2, input, 1 bit each: note enables, index 0..7 in that order; asynchronous to nothing (already clk-domain), may glitch.
REQ-006 Port audio, output, 1 bit: square-wave tone, registered.
REQ-007 Port playing, output, 1 bit: high while a note is being generated.
REQ-008 Port note_idx, output, 3 bits: index of note currently generated; 0 when not playing.
REQ-009 Port note_start, output, 1 bit: single-cycle pulse on the cycle a new note begins.

Function
REQ-010 Enable vector en[7:0] = {en_c2,en_b,en_a,en_g,en_f,en_e,en_d,en_c} SHALL be registered once (en_q) before any use.
REQ-011 Multiple set bits SHALL resolve to the lowest set index (en_c highest priority); resolved value = sel (valid flag sel_v = |en_q).
REQ-012 Settle counter: any cycle where en_q differs from its previous value SHALL reload settle count to 0; otherwise it increments, saturating at SETTLE_CYC.
REQ-013 Pattern SHALL be accepted on the cycle settle count first reaches SETTLE_CYC.
REQ-014 States: IDLE, PLAY; state register, 1 bit encoding free.
REQ-015 IDLE -> PLAY on acceptance with sel_v=1: same edge loads note_idx<=sel, cnt<=0, audio<=1, playing<=1, note_start<=1.
REQ-016 PLAY -> PLAY new note on acceptance with sel_v=1 and sel != note_idx: same loads as REQ-015 (phase restart, note_start pulses).
REQ-017 Acceptance with sel equal to current note_idx SHALL have no effect (no phase restart, no pulse).
REQ-018 PLAY -> IDLE on acceptance with sel_v=0: audio<=0, playing<=0, note_idx<=0, cnt<=0.
REQ-019 Until acceptance, current note SHALL continue unchanged (unsettled glitches never alter audio).
REQ-020 Half-period H(idx) = base(idx) >> DIV_SHIFT, base = 95556, 85131, 75843, 71587, 63776, 56818, 50619, 47778 for idx 0..7; 17-bit arithmetic.
REQ-021 In PLAY, cnt increments each cycle; when cnt == H(note_idx)-1, cnt<=0 and audio toggles; audio period = 2*H cycles, 50% duty.
REQ-022 note_start SHALL be high exactly one cycle per note start, low otherwise.
REQ-023 In IDLE, audio=0, cnt held at 0.

Reset
REQ-024 While reset is high at a rising edge: state<=IDLE, audio<=0, playing<=0, note_idx<=0, note_start<=0, cnt<=0, en_q<=0, settle count<=0.
REQ-025 Reset SHALL override all other events including acceptance in the same cycle; mid-note reset silences audio next edge.
REQ-026 After reset release, a note held throughout SHALL be accepted SETTLE_CYC+1 cycles after release (en_q change from 0 counts as a change).

Verification (SETTLE_CYC=4, DIV_SHIFT=8)
REQ-027 Reset, then en_c=1 held -> note_start pulse once, note_idx=0, audio toggles every 373 cycles (95556>>8).
REQ-028 en_a=1 and en_e=1 together -> note_idx=2, toggle every 296 cycles (75843>>8).
REQ-029 Playing C, 2-cycle glitch to en_d -> audio/note_idx unchanged, no note_start.
REQ-030 Playing C, switch to en_c2 held -> after 4 stable cycles note_idx=7, audio=1, note_start pulse, toggle every 186 cycles.
REQ-031 Playing G, all enables released -> after settle, playing=0, audio=0, note_idx=0.
REQ-032 Reset asserted mid-note with en_b held -> audio=0 next edge; after release note resumes with fresh note_start.
